// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      MEM_WAIT  = 2'd2
   } hz_state_e;

   localparam int ZERO_REG = 0;

   // Width of the load-latency down-counter; never narrower than one bit.
   function automatic int lcnt_width(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/hazard_src_match.sv
// One decode source operand compared against the destination of a load in E.
module hazard_src_match
   import hazard_pkg::*;
#(
   parameter int REG_AW      = 4,
   parameter int ZERO_REG_HW = 1
) (
   input  logic [REG_AW-1:0] src_addr,
   input  logic              src_valid,
   input  logic              e_is_load,
   input  logic [REG_AW-1:0] e_wreg,
   output logic              hit
);

   logic wreg_live;

   // A hardwired zero register can never carry a pending load result.
   assign wreg_live = (e_wreg != REG_AW'(ZERO_REG)) | (ZERO_REG_HW == 0);
   assign hit       = e_is_load & wreg_live & src_valid & (src_addr == e_wreg);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use and memory-wait hazard controller for the D/E/M stages, with a
// saturating stall-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW      = 4,
   parameter int NUM_SRC     = 2,
   parameter int LOAD_LAT    = 1,
   parameter int ZERO_REG_HW = 1,
   parameter int CNT_W       = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC*REG_AW-1:0] d_src_addr,
   input  logic [NUM_SRC-1:0]        d_src_valid,
   input  logic                      e_is_load,
   input  logic [REG_AW-1:0]         e_wreg,
   input  logic                      m_req,
   input  logic                      m_done,
   output logic                      pc_stall,
   output logic                      ifid_stall,
   output logic                      idex_stall,
   output logic                      idex_bubble,
   output logic                      exmem_stall,
   output logic [CNT_W-1:0]          stall_count
);

   localparam int                LCNT_W = lcnt_width(LOAD_LAT);
   localparam logic [LCNT_W-1:0] LAT_M1 = LCNT_W'(LOAD_LAT - 1);

   hz_state_e          state, state_nxt;
   logic [LCNT_W-1:0]  lcnt, lcnt_nxt;
   logic [NUM_SRC-1:0] src_hit;
   logic               hit;
   logic               run;
   logic               mem_hold;
   logic               load_hold;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      hazard_src_match #(
         .REG_AW      (REG_AW),
         .ZERO_REG_HW (ZERO_REG_HW)
      ) u_match (
         .src_addr  (d_src_addr[i*REG_AW +: REG_AW]),
         .src_valid (d_src_valid[i]),
         .e_is_load (e_is_load),
         .e_wreg    (e_wreg),
         .hit       (src_hit[i])
      );
   end

   assign hit = |src_hit;

   // run stays low from reset until the first clock edge after release, so the
   // stall outputs remain quiet through that window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         lcnt  <= '0;
         run   <= 1'b0;
      end else begin
         state <= state_nxt;
         lcnt  <= lcnt_nxt;
         run   <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      lcnt_nxt  = lcnt;
      if (run && !m_done) begin
         unique case (state)
            IDLE: begin
               if (m_req) begin
                  state_nxt = MEM_WAIT;
               end else if (hit && (LOAD_LAT > 1)) begin
                  state_nxt = LOAD_WAIT;
                  lcnt_nxt  = LAT_M1;
               end
            end
            LOAD_WAIT: begin
               // A memory wait parks the remaining load latency untouched.
               if (m_req) begin
                  state_nxt = MEM_WAIT;
               end else begin
                  lcnt_nxt = (lcnt != '0) ? lcnt - LCNT_W'(1) : '0;
                  if (lcnt <= LCNT_W'(1)) state_nxt = IDLE;
               end
            end
            MEM_WAIT: state_nxt = MEM_WAIT;
            default:  state_nxt = IDLE;
         endcase
      end else if (run && m_done && (state == MEM_WAIT)) begin
         state_nxt = (lcnt != '0) ? LOAD_WAIT : IDLE;
      end
   end

   always_comb begin
      mem_hold  = 1'b0;
      load_hold = 1'b0;
      if (run && !m_done) begin
         unique case (state)
            IDLE: begin
               if (m_req)    mem_hold  = 1'b1;
               else if (hit) load_hold = 1'b1;
            end
            LOAD_WAIT: begin
               if (m_req) mem_hold  = 1'b1;
               else       load_hold = 1'b1;
            end
            MEM_WAIT: mem_hold = 1'b1;
            default: begin
               mem_hold  = 1'b0;
               load_hold = 1'b0;
            end
         endcase
      end
   end

   assign pc_stall    = mem_hold | load_hold;
   assign ifid_stall  = mem_hold | load_hold;
   assign idex_stall  = mem_hold;
   assign exmem_stall = mem_hold;
   assign idex_bubble = load_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (pc_stall && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller sitting between the decode (D), execute (E) and memory (M) stages of the CPU pipeline. It detects load-use hazards across any number of decode source operands, holds the front of the pipeline for a configurable load latency, freezes the whole pipeline while a multi-cycle memory access is outstanding, and keeps a saturating count of stall cycles for performance analysis.

## Interface
- REG_AW, 4: register address width.
- NUM_SRC, 2: number of decode-stage source operands checked.
- LOAD_LAT, 1: extra cycles a load result is unavailable after E; legal range ≥1.
- ZERO_REG_HW, 1: when 1, register 0 is hardwired and never causes a hazard.
- CNT_W, 16: width of stall-cycle counter.

- clk  in  1  pipeline clock.
- rst_n  in  1  reset; asynchronous, active-low.
- d_src_addr  in  NUM_SRC*REG_AW  packed decode source addresses; source i at [i*REG_AW +: REG_AW].
- d_src_valid  in  NUM_SRC  source i actually read by the decode instruction (immediate-only ops drive 0).
- e_is_load  in  1  instruction in E is a load.
- e_wreg  in  REG_AW  destination register of the E instruction.
- m_req  in  1  M stage starts a memory access this cycle.
- m_done  in  1  memory access complete (write_done equivalent).
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID register.
- idex_stall  out  1  hold ID/EX register (memory wait only).
- idex_bubble  out  1  load NOP into ID/EX (load-use only).
- exmem_stall  out  1  hold EX/MEM register.
- stall_count  out  CNT_W  saturating count of cycles with pc_stall=1.

## Operation
- hit = e_is_load & (e_wreg≠0 or ZERO_REG_HW=0) & OR over i of (d_src_valid[i] & d_src_addr[i]==e_wreg).
- FSM states: IDLE, LOAD_WAIT, MEM_WAIT; down-counter lcnt, width $clog2(LOAD_LAT+1).
- IDLE:
  - m_req & !m_done → outputs memory stall set this cycle; next MEM_WAIT.
  - else hit → pc_stall=ifid_stall=idex_bubble=1; if LOAD_LAT>1 next LOAD_WAIT, lcnt=LOAD_LAT-1; else stay IDLE.
  - else all stalls 0.
- LOAD_WAIT: pc_stall=ifid_stall=idex_bubble=1; lcnt decrements; at lcnt==1 next IDLE. m_req & !m_done here → MEM_WAIT with lcnt preserved; on return, resume LOAD_WAIT if lcnt>0.
- MEM_WAIT: pc_stall=ifid_stall=idex_stall=exmem_stall=1, idex_bubble=0. m_done=1 → all stalls 0 that same cycle; next LOAD_WAIT if lcnt>0 else IDLE.
- Memory wait has priority over load-use; idex_stall and idex_bubble never both 1.
- m_done=1 in any state forces every stall output to 0 for that cycle.
- m_req and m_done in the same cycle: no stall, no state change.
- stall_count increments each cycle pc_stall=1; saturates at all-ones.

## Timing
- Reset (rst_n low, any time): state IDLE, lcnt 0, stall_count 0, all stall outputs 0 immediately (asynchronous), held until first clk edge after release.
- Stall outputs are combinational from state, lcnt and current inputs: a hit stalls in the same cycle it appears.
- Load-use with LOAD_LAT=N costs exactly N stall cycles, N bubbles.
- Memory stall lasts from the m_req cycle up to, not including, the m_done cycle.
- State, lcnt, stall_count update on rising clk only.

## Structure
- hazard_pkg: state enum type (IDLE/LOAD_WAIT/MEM_WAIT), constant for zero register, helper function for lcnt width.
- Sub-module hazard_src_match: one instance per source, compares address/valid against e_wreg and applies the zero-register rule; top ORs the results.
- Top holds FSM, lcnt and stall_count.

## Test plan
- NUM_SRC=2, LOAD_LAT=1: E load r5, D src1=r5 valid → one cycle pc_stall=ifid_stall=idex_bubble=1, then 0; stall_count=1.
- LOAD_LAT=3: E load r7, D src0=r7 → exactly 3 stall/bubble cycles, FSM IDLE→LOAD_WAIT→IDLE; stall_count=3.
- E load r0 with ZERO_REG_HW=1, D src0=r0 → no stall; same with d_src_valid=0 and r5 match → no stall.
- m_req at cycle 10, m_done at cycle 14 → pc/ifid/idex/exmem stall high cycles 10-13, low 14; m_req&m_done same cycle → no stall.
- LOAD_LAT=3 load-use, m_req mid-LOAD_WAIT with lcnt=2 → MEM_WAIT until m_done, then 2 more bubble cycles; rst_n pulsed mid-MEM_WAIT → all outputs 0 immediately, stall_count 0.
- stall_count with CNT_W=4: hold memory stall 20 cycles → counter saturates at 15.
